// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// buffering with branch flush and discard of stale in-flight responses.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    input  logic        br_taken,
    input  logic [63:0] br_target,

    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic [6:0]  if_opcode,

    output logic        err_spurious
);

    // Counters hold 0..DEPTH; pointers index the DEPTH-entry ring.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [63:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] buf_count_q, buf_count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             err_spurious_q, err_spurious_d;

    logic [31:0]      buf_instr_q [DEPTH];
    logic [63:0]      buf_pc_q    [DEPTH];

    logic             credit_ok;
    logic             req_fire;
    logic             rsp_accept;
    logic             rsp_spurious;
    logic             push;
    logic             pop;
    logic [63:0]      br_pc;
    logic             unused_br_lsb;

    assign br_pc         = {br_target[63:2], 2'b00};
    assign unused_br_lsb = ^br_target[1:0];

    assign credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count_q}) < (CNT_W + 1)'(DEPTH);

    // NOTE: the credit test alone is true out of reset, so rst_n gates the
    // request combinationally to keep it low for the whole reset assertion.
    assign imem_req_valid = rst_n & credit_ok & ~br_taken;
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_accept   = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_spurious = imem_rsp_valid & (outstanding_q == '0);
    assign push         = rsp_accept & (discard_q == '0) & ~br_taken;

    assign if_valid     = (buf_count_q != '0);
    assign if_instr     = buf_instr_q[rd_ptr_q];
    assign if_pc        = buf_pc_q[rd_ptr_q];
    assign if_opcode    = if_instr[6:0];
    assign pop          = if_valid & id_ready;
    assign err_spurious = err_spurious_q;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        rsp_pc_d       = rsp_pc_q;
        outstanding_d  = outstanding_q;
        discard_d      = discard_q;
        buf_count_d    = buf_count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        err_spurious_d = err_spurious_q | rsp_spurious;

        case ({req_fire, rsp_accept})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (br_taken) begin
            // Everything still in flight belongs to the wrong path; a response
            // landing this cycle is already retired from that count.
            fetch_pc_d  = br_pc;
            rsp_pc_d    = br_pc;
            discard_d   = rsp_accept ? (outstanding_q - CNT_W'(1)) : outstanding_q;
            buf_count_d = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end

            if (rsp_accept && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end

            if (push) begin
                rsp_pc_d = rsp_pc_q + 64'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   buf_count_d = buf_count_q + CNT_W'(1);
                2'b01:   buf_count_d = buf_count_q - CNT_W'(1);
                default: buf_count_d = buf_count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q     <= RESET_PC;
            rsp_pc_q       <= RESET_PC;
            outstanding_q  <= '0;
            discard_q      <= '0;
            buf_count_q    <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            rsp_pc_q       <= rsp_pc_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
            buf_count_q    <= buf_count_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    // NOTE: buffer storage is deliberately not reset; if_valid qualifies every
    // read, so only the count and pointers need a defined reset value.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_rsp_data;
            buf_pc_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order 1-cycle memory model plus a
// decode-side monitor that checks every accepted instruction against the expected PC.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        br_taken;
    logic [63:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [6:0]  if_opcode;
    logic        err_spurious;

    logic        imem_req_valid2;
    logic [63:0] imem_addr2;
    logic        unused2_if_valid;
    logic [31:0] unused2_if_instr;
    logic [63:0] unused2_if_pc;
    logic [6:0]  unused2_if_opcode;
    logic        unused2_err;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_pop   = 0;
    int          p0;
    logic [63:0] mq[$];
    logic [63:0] fire_log[$];
    logic [63:0] fire2_log[$];
    logic [63:0] exp_pc;
    bit          rsp_en;
    bit          spur_pulse;
    bit          last_rsp;
    bit          last_pop;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .br_taken(br_taken), .br_target(br_target), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode),
        .err_spurious(err_spurious)
    );

    instr_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr2),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .br_taken(1'b0), .br_target(64'h0), .id_ready(1'b1),
        .if_valid(unused2_if_valid), .if_instr(unused2_if_instr), .if_pc(unused2_if_pc),
        .if_opcode(unused2_if_opcode), .err_spurious(unused2_err)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        return {a[26:2], a[8:2] ^ 7'h33};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic        took_rsp;
        logic        fire;
        logic        fire2;
        logic [63:0] faddr;
        logic [31:0] w;
        took_rsp = 1'b0;
        if (spur_pulse) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (rsp_en && mq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(mq[0]);
            took_rsp       = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        fire     = imem_req_valid & imem_req_ready;
        faddr    = imem_addr;
        fire2    = imem_req_valid2 & imem_req_ready;
        last_rsp = imem_rsp_valid;
        last_pop = if_valid & id_ready;
        if (if_valid && id_ready) begin
            w = word(exp_pc);
            check("pop_pc", if_pc, exp_pc);
            check("pop_instr", 64'(if_instr), 64'(w));
            check("pop_opcode", 64'(if_opcode), 64'(w[6:0]));
            exp_pc = exp_pc + 64'd4;
            n_pop++;
        end
        if (br_taken) exp_pc = {br_target[63:2], 2'b00};
        @(posedge clk);
        if (took_rsp) void'(mq.pop_front());
        if (fire) begin
            mq.push_back(faddr);
            fire_log.push_back(faddr);
        end
        if (fire2) fire2_log.push_back(imem_addr2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        br_taken       = 1'b0;
        spur_pulse     = 1'b0;
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        mq.delete();
        fire_log.delete();
        fire2_log.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 64'h0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        br_taken       = 1'b0;
        br_target      = 64'h0;
        id_ready       = 1'b1;
        rsp_en         = 1'b0;
        spur_pulse     = 1'b0;
        exp_pc         = 64'h0;

        #2;
        check("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check("rst_if_valid", 64'(if_valid), 64'h0);
        check("rst_err", 64'(err_spurious), 64'h0);
        check("rst_addr", imem_addr, 64'h0);

        // Streaming fetch from reset.
        do_reset();
        rsp_en = 1'b1;
        step();
        check("first_req_cnt", 64'(fire_log.size()), 64'd1);
        check("first_req_addr", fire_log[0], 64'h0);
        repeat (7) step();
        check("req_addr_1", fire_log[1], 64'h4);
        check("req_addr_2", fire_log[2], 64'h8);
        check("stream_pops", 64'(n_pop >= 3), 64'h1);
        check("wrap_req_cnt", 64'(fire2_log.size()), 64'd2);
        check("wrap_req_0", fire2_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_req_1", fire2_log[1], 64'h0);

        // Decode stall fills the buffer and holds the head.
        id_ready = 1'b0;
        repeat (10) step();
        check("stall_if_valid", 64'(if_valid), 64'h1);
        check("stall_req_low", 64'(imem_req_valid), 64'h0);
        check("stall_buf_full", 64'(dut.buf_count_q), 64'd2);
        check("stall_head_pc", if_pc, exp_pc);
        check("stall_head_instr", 64'(if_instr), 64'(word(exp_pc)));
        id_ready = 1'b1;
        p0 = n_pop;
        repeat (8) step();
        check("release_pops", 64'(n_pop - p0 >= 4), 64'h1);
        id_ready = 1'b0;
        repeat (4) step();
        check("pre_rst_valid", 64'(if_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_if_valid", 64'(if_valid), 64'h0);
        check("async_req_valid", 64'(imem_req_valid), 64'h0);
        check("async_pc", imem_addr, 64'h0);
        @(negedge clk);

        // Branch with two requests in flight.
        id_ready = 1'b1;
        rsp_en   = 1'b0;
        do_reset();
        br_taken  = 1'b1;
        br_target = 64'h10;
        step();
        br_taken = 1'b0;
        repeat (3) step();
        check("inflight_cnt", 64'(fire_log.size()), 64'd2);
        check("inflight_0", fire_log[0], 64'h10);
        check("inflight_1", fire_log[1], 64'h14);
        br_taken  = 1'b1;
        br_target = 64'h103;
        step();
        br_taken = 1'b0;
        check("br_discard", 64'(dut.discard_q), 64'd2);
        fire_log.delete();
        rsp_en = 1'b1;
        p0 = n_pop;
        repeat (8) step();
        check("br_next_req", fire_log[0], 64'h100);
        check("br_pops", 64'(n_pop - p0 >= 2), 64'h1);

        // Branch coinciding with a response and a pop.
        do_reset();
        rsp_en = 1'b1;
        repeat (2) step();
        br_taken  = 1'b1;
        br_target = 64'h2000;
        step();
        br_taken = 1'b0;
        check("coin_rsp", 64'(last_rsp), 64'h1);
        check("coin_pop", 64'(last_pop), 64'h1);
        check("coin_discard", 64'(dut.discard_q), 64'd0);
        check("coin_flush", 64'(dut.buf_count_q), 64'd0);
        p0 = n_pop;
        repeat (8) step();
        check("coin_pops", 64'(n_pop - p0 >= 2), 64'h1);

        // Spurious response with nothing outstanding.
        imem_req_ready = 1'b0;
        rsp_en         = 1'b0;
        do_reset();
        repeat (2) step();
        check("hold_req_valid", 64'(imem_req_valid), 64'h1);
        spur_pulse = 1'b1;
        step();
        spur_pulse = 1'b0;
        check("spur_err", 64'(err_spurious), 64'h1);
        check("spur_no_push", 64'(if_valid), 64'h0);
        check("spur_outstanding", 64'(dut.outstanding_q), 64'd0);
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        p0 = n_pop;
        repeat (6) step();
        check("spur_sticky", 64'(err_spurious), 64'h1);
        check("spur_pops", 64'(n_pop - p0 >= 2), 64'h1);
        rst_n = 1'b0;
        #1;
        check("spur_cleared", 64'(err_spurious), 64'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
